// File: rtl/prog_loader_pkg.sv
// Shared MIPS-side definitions: loader states and memory sizing.
// The default depth is shared with the instruction/data memory.
package mips_pkg;
  localparam int WORDS_DEF      = 64;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } ld_state_t;
endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in and memory write port out of the program loader.
// master = stream source / memory side, slave = the loader.
interface prog_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wd;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  mem_we,
    input  mem_adr,
    input  mem_wd
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output mem_we,
    output mem_adr,
    output mem_wd
  );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Big-endian byte-to-word packer with running XOR checksum.
// word_full flags the byte that completes the current word.
module byte_packer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] pack,
  output logic [7:0]  csum,
  output logic        word_full
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0] cnt;

  assign word_full = en && (cnt == LAST_BYTE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack <= '0;
      csum <= '0;
      cnt  <= '0;
    end else if (clr) begin
      csum <= '0;
      cnt  <= '0;
    end else if (en) begin
      pack <= {pack[23:0], din};
      csum <= csum ^ din;
      cnt  <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: streams bytes into memory words,
// verifies an XOR checksum and releases the CPU on success.
module prog_loader
  import mips_pkg::*;
#(
  parameter int WORDS = WORDS_DEF,
  parameter int NW_W  = $clog2(WORDS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [NW_W-1:0] nwords,
  prog_loader_if.slave    bus,
  output logic            cpu_reset,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int IW = $clog2(WORDS);

  ld_state_t       state, next;
  logic [IW-1:0]   idx;
  logic [NW_W-1:0] nw_q;
  logic [NW_W-1:0] idx_inc;
  logic            start_ok;
  logic            clr;
  logic            accept;
  logic            pk_en;
  logic            word_full;
  logic [31:0]     pack;
  logic [7:0]      csum;

  assign start_ok = start && (nwords != '0)
                 && (nwords <= NW_W'(WORDS));
  assign accept   = bus.byte_valid && bus.byte_ready;
  assign pk_en    = accept && (state == RECV);
  assign idx_inc  = NW_W'(idx) + NW_W'(1);

  byte_packer u_pk (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .en        (pk_en),
    .din       (bus.byte_in),
    .pack      (pack),
    .csum      (csum),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      nw_q  <= '0;
    end else begin
      state <= next;
      if (clr) begin
        idx  <= '0;
        nw_q <= nwords;
      end else if (state == WRITE) begin
        idx <= idx + IW'(1);
      end
    end
  end

  always_comb begin
    next = state;
    clr  = 1'b0;
    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          next = start_ok ? RECV : ERROR;
          clr  = start_ok;
        end
      end
      RECV: begin
        if (word_full) next = WRITE;
      end
      WRITE: begin
        next = (idx_inc == nw_q) ? CHECK : RECV;
      end
      CHECK: begin
        if (accept)
          next = (bus.byte_in == csum) ? DONE : ERROR;
      end
      default: next = IDLE;
    endcase
  end

  always_comb begin
    bus.byte_ready = (state == RECV) || (state == CHECK);
    bus.mem_we     = (state == WRITE);
    bus.mem_adr    = 32'({idx, 2'b00});
    bus.mem_wd     = pack;
    busy           = (state == RECV) || (state == WRITE)
                  || (state == CHECK);
    cpu_reset      = (state != DONE);
    done           = (state == DONE);
    err            = (state == ERROR);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued as
// bytes are driven, popped and compared on each mem_we.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] nwords = '0;
  logic       cpu_reset, busy, done, err;

  prog_loader_if bus ();

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .nwords    (nwords),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  logic [31:0] last_adr = '0;
  logic [63:0] sbq[$];
  logic [63:0] exp_e;
  logic [31:0] wbuf[64];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.mem_we === 1'b1) begin
      we_cnt++;
      last_adr = bus.mem_adr;
      chk("rdy_in_write", 32'(bus.byte_ready), 32'd0);
      chk("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        exp_e = sbq.pop_front();
        chk("mem_adr", bus.mem_adr, exp_e[63:32]);
        chk("mem_wd", bus.mem_wd, exp_e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (bus.byte_ready !== 1'b1 && t < 40) begin
      t++;
      @(negedge clk);
    end
    chk("rdy_timeout", 32'(t < 40), 32'd1);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_start(input logic [6:0] n);
    start  = 1'b1;
    nwords = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic load(input int n, input bit good, input int gmax);
    logic [7:0] cs;
    logic [7:0] b;
    cs = '0;
    do_start(7'(n));
    for (int i = 0; i < n; i++) begin
      sbq.push_back({32'(i * 4), wbuf[i]});
      for (int k = 0; k < 4; k++) begin
        b  = 8'(wbuf[i] >> (24 - 8 * k));
        cs = cs ^ b;
        send_byte(b, int'($urandom_range(0, gmax)));
      end
    end
    send_byte(good ? cs : cs + 8'd1, 0);
    @(negedge clk);
    chk("done", 32'(done), 32'(good));
    chk("err", 32'(err), 32'(!good));
    chk("cpu_reset", 32'(cpu_reset), 32'(!good));
    chk("busy_after", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
  endtask

  task automatic bad_start(input logic [6:0] n);
    int w0, rdy;
    w0  = we_cnt;
    rdy = 0;
    do_start(n);
    @(negedge clk);
    chk("bad_n_err", 32'(err), 32'd1);
    chk("bad_n_busy", 32'(busy), 32'd0);
    bus.byte_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) rdy++;
    end
    bus.byte_valid = 1'b0;
    chk("bad_n_rdy", 32'(rdy), 32'd0);
    chk("bad_n_we", 32'(we_cnt - w0), 32'd0);
  endtask

  initial begin
    int w0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_adr", bus.mem_adr, 32'd0);
    chk("rst_wd", bus.mem_wd, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    w0 = we_cnt;
    wbuf[0] = 32'h2002_0005;
    load(1, 1'b1, 0);
    chk("one_word_we", 32'(we_cnt - w0), 32'd1);

    w0 = we_cnt;
    wbuf[0] = 32'h8C02_0004;
    wbuf[1] = 32'hAC03_0008;
    load(2, 1'b1, 2);
    chk("two_word_we", 32'(we_cnt - w0), 32'd2);

    wbuf[0] = 32'h2002_0005;
    load(1, 1'b0, 0);
    load(1, 1'b1, 1);

    bad_start(7'd0);
    bad_start(7'd65);

    w0 = we_cnt;
    for (int i = 0; i < 64; i++)
      wbuf[i] = 32'h1000_0000 + 32'(i * 3);
    load(64, 1'b1, 0);
    chk("full_we", 32'(we_cnt - w0), 32'd64);
    chk("full_last_adr", last_adr, 32'h0000_00FC);

    w0 = we_cnt;
    do_start(7'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_start(7'd0);
    @(negedge clk);
    chk("start_ign_busy", 32'(busy), 32'd1);
    chk("start_ign_err", 32'(err), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_cpu", 32'(cpu_reset), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_no_we", 32'(we_cnt - w0), 32'd0);
    wbuf[0] = 32'h1122_3344;
    load(1, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
